// File: rtl/id_scan_arb.sv
// Round-robin arbiter that lends one identifier-recognizer FSM to two string
// requesters, streaming whole strings and returning verdict/length/error.
module id_scan_arb #(
  parameter logic [7:0] SEP     = 8'h20,
  parameter int         RES_LAT = 1,
  parameter int         MAX_LEN = 32,
  parameter int         LEN_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [1:0]       vld,
  input  logic [1:0]       last,
  input  logic [7:0]       char0,
  input  logic [7:0]       char1,
  output logic [1:0]       rdy,
  output logic [1:0]       done,
  output logic             is_id,
  output logic [LEN_W-1:0] len,
  output logic             err,
  output logic             busy,
  output logic [7:0]       char_o,
  input  logic             id_i,
  output logic [2:0]       dbg_state
);

  // Handshake: a char moves on vld[g] & rdy[g] at a rising edge; rdy is only
  // ever high for the granted channel, and the granted stream must not gap.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_LEN);
  localparam logic [2:0]       WAIT_END = 3'(RES_LAT);

  state_t           r_state;
  logic             r_g;
  logic             r_last_g;
  logic [LEN_W-1:0] r_cnt;
  logic             r_err;
  logic [2:0]       r_wcnt;
  logic [1:0]       r_rdy;
  logic [1:0]       r_done;
  logic             r_is_id;
  logic [LEN_W-1:0] r_len;
  logic             r_err_o;
  logic             r_busy;
  logic [7:0]       r_char;

  logic       w_req;
  logic       w_vld;
  logic       w_last;
  logic [7:0] w_char;
  logic       w_g;
  logic       w_full;

  assign w_req  = r_g ? req[1]  : req[0];
  assign w_vld  = r_g ? vld[1]  : vld[0];
  assign w_last = r_g ? last[1] : last[0];
  assign w_char = r_g ? char1   : char0;
  // On contention the channel that did not win last time gets the grant.
  assign w_g    = (req == 2'b11) ? ~r_last_g : req[1];
  assign w_full = (r_cnt == MAX_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_g      <= 1'b0;
      r_last_g <= 1'b1;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_wcnt   <= '0;
      r_rdy    <= 2'b00;
      r_done   <= 2'b00;
      r_is_id  <= 1'b0;
      r_len    <= '0;
      r_err_o  <= 1'b0;
      r_busy   <= 1'b0;
      r_char   <= SEP;
    end else begin
      r_char <= SEP;
      r_done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_g      <= w_g;
            r_last_g <= w_g;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_rdy    <= {w_g, ~w_g};
            r_busy   <= 1'b1;
            r_state  <= S_FEED;
          end
        end
        S_FEED: begin
          if (!w_req || !w_vld) begin
            r_err   <= 1'b1;
            r_state <= S_DRAIN;
          end else if (w_full) begin
            // Overlong string: the extra char is dropped, count stays saturated.
            r_err <= 1'b1;
            if (w_last) begin
              r_rdy   <= 2'b00;
              r_wcnt  <= '0;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_DRAIN;
            end
          end else begin
            r_char <= w_char;
            r_cnt  <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_rdy   <= 2'b00;
              r_wcnt  <= '0;
              r_state <= S_WAIT;
            end
          end
        end
        S_DRAIN: begin
          if (!w_req || (w_vld && w_last)) begin
            r_rdy   <= 2'b00;
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // The last forwarded char was on char_o in the first WAIT cycle, so
          // its verdict is on id_i RES_LAT cycles later.
          if (r_wcnt == WAIT_END) begin
            r_done  <= {r_g, ~r_g};
            r_is_id <= id_i & ~r_err;
            r_len   <= r_cnt;
            r_err_o <= r_err;
            r_state <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + 3'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_rdy   <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign done      = r_done;
  assign is_id     = r_is_id;
  assign len       = r_len;
  assign err       = r_err_o;
  assign busy      = r_busy;
  assign char_o    = r_char;
  assign dbg_state = r_state;

endmodule
